// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over req/ack instruction and data ports.
// Define MIPS_MC_PERF_EN to add the cycleCnt/instCnt performance counter outputs.
module mips_mc_core #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              REG_NUM  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              instReq,
  output logic [PC_W-1:0]   instAddr,
  input  logic [31:0]       instData,
  input  logic              instAck,
  output logic              dataReq,
  output logic              dataWe,
  output logic [PC_W-1:0]   dataAddr,
  output logic [DATA_W-1:0] dataWData,
  input  logic [DATA_W-1:0] dataRData,
  input  logic              dataAck,
  output logic              retire,
  output logic              illegal
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]       cycleCnt,
  output logic [31:0]       instCnt
`endif
);

  localparam int              RA_W     = $clog2(REG_NUM);
  localparam logic [RA_W-1:0] LINK_REG = RA_W'(REG_NUM - 1);
  localparam logic [PC_W-1:0] J_MASK   = PC_W'(32'h0FFF_FFFF);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {K_ALU, K_LD, K_ST, K_CTL, K_ILL} kind_t;

  state_t state, stateNext;
  kind_t  kind;

  logic [31:0]       ir;
  logic [PC_W-1:0]   pc, pcPlus4, brTgt, jTgt, ctlPc;
  logic [DATA_W-1:0] regA, regB, immExt, aluOut, aluRes;
  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [RA_W-1:0]   rs, rt, rd, dst, wbDst;
  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic              wbEn, link;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign shamt    = ir[10:6] & 5'(DATA_W - 1);
  assign rs       = ir[21 +: RA_W];
  assign rt       = ir[16 +: RA_W];
  assign rd       = ir[11 +: RA_W];
  assign instAddr = pc;
  assign pcPlus4  = pc + PC_W'(4);
  assign brTgt    = pcPlus4 + (PC_W'($signed(ir[15:0])) << 2);
  assign jTgt     = (pcPlus4 & ~J_MASK) | (PC_W'({ir[25:0], 2'b00}) & J_MASK);

  // Instruction classification and ALU, evaluated on the latched IR/A/B during EXEC.
  always_comb begin
    kind   = K_ALU;
    aluRes = '0;
    dst    = rt;
    ctlPc  = pcPlus4;
    link   = 1'b0;
    case (opcode)
      6'h00: begin
        dst = rd;
        case (funct)
          6'h20, 6'h21: aluRes = regA + regB;
          6'h22, 6'h23: aluRes = regA - regB;
          6'h24:        aluRes = regA & regB;
          6'h25:        aluRes = regA | regB;
          6'h26:        aluRes = regA ^ regB;
          6'h2a:        aluRes = DATA_W'($signed(regA) < $signed(regB));
          6'h00:        aluRes = regB << shamt;
          6'h02:        aluRes = regB >> shamt;
          6'h08: begin
            kind  = K_CTL;
            ctlPc = PC_W'(regA);
          end
          default:      kind = K_ILL;
        endcase
      end
      6'h08, 6'h09: aluRes = regA + immExt;
      6'h0c:        aluRes = regA & immExt;
      6'h0d:        aluRes = regA | immExt;
      6'h0e:        aluRes = regA ^ immExt;
      6'h0f:        aluRes = immExt;
      6'h23:        kind = K_LD;
      6'h2b:        kind = K_ST;
      6'h04: begin
        kind = K_CTL;
        if (regA == regB) ctlPc = brTgt;
      end
      6'h05: begin
        kind = K_CTL;
        if (regA != regB) ctlPc = brTgt;
      end
      6'h02: begin
        kind  = K_CTL;
        ctlPc = jTgt;
      end
      6'h03: begin
        kind  = K_CTL;
        ctlPc = jTgt;
        link  = 1'b1;
      end
      default: kind = K_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH:  if (instReq && instAck) stateNext = DECODE;
      DECODE: stateNext = EXEC;
      EXEC: begin
        illegal = (kind == K_ILL);
        case (kind)
          K_LD, K_ST: stateNext = MEM;
          K_CTL: begin
            retire    = 1'b1;
            stateNext = FETCH;
          end
          default:    stateNext = WB;
        endcase
      end
      MEM: begin
        if (dataReq && dataAck) begin
          if (dataWe) begin
            retire    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WB;
          end
        end
      end
      WB: begin
        retire    = 1'b1;
        stateNext = FETCH;
      end
      default: stateNext = FETCH;
    endcase
  end

  // Request strobes are registered from the next state so they are clean and drop on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      regA      <= '0;
      regB      <= '0;
      immExt    <= '0;
      aluOut    <= '0;
      wbDst     <= '0;
      wbEn      <= 1'b0;
      instReq   <= 1'b0;
      dataReq   <= 1'b0;
      dataWe    <= 1'b0;
      dataAddr  <= '0;
      dataWData <= '0;
      for (int i = 0; i < REG_NUM; i++) gpr[i] <= '0;
    end else begin
      instReq <= (stateNext == FETCH);
      dataReq <= (stateNext == MEM);
      case (state)
        FETCH: if (instReq && instAck) ir <= instData;
        DECODE: begin
          regA <= gpr[rs];
          regB <= gpr[rt];
          case (opcode)
            6'h0c, 6'h0d, 6'h0e: immExt <= DATA_W'(ir[15:0]);
            6'h0f:               immExt <= DATA_W'({ir[15:0], 16'h0000});
            default:             immExt <= DATA_W'($signed(ir[15:0]));
          endcase
        end
        EXEC: begin
          aluOut <= aluRes;
          wbDst  <= dst;
          wbEn   <= (kind == K_ALU) || (kind == K_LD);
          if (kind == K_CTL) pc <= ctlPc;
          if (link) gpr[LINK_REG] <= DATA_W'(pcPlus4);
          if (kind == K_LD || kind == K_ST) begin
            dataAddr  <= PC_W'(regA + immExt);
            dataWe    <= (kind == K_ST);
            dataWData <= regB;
          end
        end
        MEM: begin
          if (dataReq && dataAck) begin
            dataWe <= 1'b0;
            if (dataWe) pc <= pcPlus4;
            else        aluOut <= dataRData;
          end
        end
        WB: begin
          if (wbEn && wbDst != '0) gpr[wbDst] <= aluOut;
          pc <= pcPlus4;
        end
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCnt <= '0;
      instCnt  <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (retire) instCnt <= instCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core with a wait-state-capable req/ack memory model.
module tb_mips_mc_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instReq, instAck, dataReq, dataWe, dataAck, retire, illegal;
  logic [31:0] instAddr, instData, dataAddr, dataWData, dataRData;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cycleCnt, instCnt;
`endif

  mips_mc_core #(.DATA_W(32), .PC_W(32), .REG_NUM(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .instReq(instReq), .instAddr(instAddr), .instData(instData), .instAck(instAck),
    .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWData(dataWData),
    .dataRData(dataRData), .dataAck(dataAck), .retire(retire), .illegal(illegal)
`ifdef MIPS_MC_PERF_EN
    , .cycleCnt(cycleCnt), .instCnt(instCnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int instWait = 0, dataWait = 0, iCnt = 0, dCnt = 0;
  int nTests = 0, nFail = 0;

  initial begin
    instAck = 1'b0; dataAck = 1'b0; instData = '0; dataRData = '0;
  end

  // Memory model: ack after the configured number of wait cycles while req is held.
  always @(posedge clk) begin
    #1;
    if (instReq) begin
      instAck = (iCnt == instWait);
      if (instAck) instData = imem[instAddr[9:2]];
      iCnt++;
    end else begin
      instAck = 1'b0; iCnt = 0;
    end
    if (dataReq) begin
      dataAck = (dCnt == dataWait);
      if (dataAck) begin
        if (dataWe) dmem[dataAddr[7:2]] = dataWData;
        else        dataRData = dmem[dataAddr[7:2]];
      end
      dCnt++;
    end else begin
      dataAck = 1'b0; dCnt = 0;
    end
  end

  function automatic logic [31:0] rT(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] iT(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jT(input int op, input int idx);
    return {6'(op), 26'(idx)};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask

  task automatic loadDefaults();
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000FFFF;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    instWait = 0; dataWait = 0;
  endtask

  task automatic boot();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int retCyc[$];
  logic [31:0] fetchAddr[$];
  int illCnt, nR, instUnstable, dataUnstable;

  // Runs until nRet retires or the cycle budget expires; cycle 1 is the first negedge after boot.
  task automatic runProg(input int nRet, input int budget);
    int cyc = 0;
    logic pIR = 1'b0, pDR = 1'b0;
    logic [31:0] pIA = '0, pDA = '0, pWD = '0;
    logic pWe = 1'b0;
    retCyc.delete(); fetchAddr.delete();
    illCnt = 0; nR = 0; instUnstable = 0; dataUnstable = 0;
    while (nR < nRet && cyc < budget) begin
      @(negedge clk); cyc++;
      if (instReq && pIR && instAddr !== pIA) instUnstable++;
      if (dataReq && pDR && (dataAddr !== pDA || dataWData !== pWD || dataWe !== pWe)) dataUnstable++;
      pIR = instReq; pIA = instAddr; pDR = dataReq; pDA = dataAddr; pWD = dataWData; pWe = dataWe;
      if (instReq && instAck) fetchAddr.push_back(instAddr);
      if (illegal) illCnt++;
      if (retire) begin retCyc.push_back(cyc); nR++; end
    end
  endtask

  task automatic test_reset();
    loadDefaults(); instWait = 50;
    boot();
    repeat (3) @(negedge clk);
    nTests++; if (instReq !== 1'b1) begin nFail++; $display("FAIL rst_prefetch_req: got %b want 1", instReq); end
    rst = 1'b0; #1;
    nTests++; if (instReq !== 1'b0) begin nFail++; $display("FAIL rst_instReq: got %b want 0", instReq); end
    nTests++; if (instAddr !== 32'h100) begin nFail++; $display("FAIL rst_instAddr: got %h want 00000100", instAddr); end
    nTests++; if ({dataReq, dataWe, retire, illegal} !== 4'b0) begin nFail++; $display("FAIL rst_strobes: got %b want 0000", {dataReq, dataWe, retire, illegal}); end
    nTests++; if ({dataAddr, dataWData} !== 64'h0) begin nFail++; $display("FAIL rst_data_bus: got %h want 0", {dataAddr, dataWData}); end
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    nTests++; if (instReq !== 1'b0) begin nFail++; $display("FAIL rst_release_req: got %b want 0", instReq); end
    @(negedge clk);
    nTests++; if ({instReq, instAddr} !== {1'b1, 32'h100}) begin nFail++; $display("FAIL rst_first_fetch: got %b/%h want 1/00000100", instReq, instAddr); end
  endtask

  task automatic test_alu_chain();
    loadDefaults();
    put(32'h100, iT('h0d, 0, 1, 16'h00FF));
    put(32'h104, rT(1, 1, 2, 0, 'h21));
    put(32'h108, rT(0, 1, 3, 0, 'h23));
    put(32'h10C, iT('h2b, 0, 2, 16'h0000));
    put(32'h110, iT('h2b, 0, 3, 16'h0004));
    boot();
    runProg(5, 100);
    nTests++; if (nR != 5) begin nFail++; $display("FAIL alu_timeout: got %0d retires want 5", nR); end
    for (int i = 0; i < 5 && i < retCyc.size(); i++) begin
      nTests++; if (retCyc[i] != 4 * (i + 1)) begin nFail++; $display("FAIL alu_retire_cycle[%0d]: got %0d want %0d", i, retCyc[i], 4 * (i + 1)); end
    end
    nTests++; if (dmem[0] !== 32'h000001FE) begin nFail++; $display("FAIL alu_addu: got %h want 000001FE", dmem[0]); end
    nTests++; if (dmem[1] !== 32'hFFFFFF01) begin nFail++; $display("FAIL alu_subu: got %h want FFFFFF01", dmem[1]); end
  endtask

  task automatic test_wait_states();
    loadDefaults(); instWait = 3; dataWait = 2;
    dmem[1] = 32'hDEADBEEF;
    put(32'h100, iT('h23, 0, 4, 16'h0004));
    put(32'h104, iT('h2b, 0, 4, 16'h0008));
    boot();
    runProg(2, 100);
    nTests++; if (nR != 2) begin nFail++; $display("FAIL wait_timeout: got %0d retires want 2", nR); end
    nTests++; if (retCyc.size() < 1 || retCyc[0] != 10) begin nFail++; $display("FAIL wait_lw_cycle: got %0d want 10", retCyc.size() ? retCyc[0] : -1); end
    nTests++; if (retCyc.size() < 2 || retCyc[1] != 19) begin nFail++; $display("FAIL wait_sw_cycle: got %0d want 19", retCyc.size() > 1 ? retCyc[1] : -1); end
    nTests++; if (instUnstable != 0) begin nFail++; $display("FAIL wait_instAddr_stable: got %0d changes want 0", instUnstable); end
    nTests++; if (dataUnstable != 0) begin nFail++; $display("FAIL wait_data_stable: got %0d changes want 0", dataUnstable); end
    nTests++; if (dmem[2] !== 32'hDEADBEEF) begin nFail++; $display("FAIL wait_lw_data: got %h want DEADBEEF", dmem[2]); end
  endtask

  task automatic test_control_flow();
    logic [31:0] expA [11];
    expA = '{32'h100, 32'h104, 32'h110, 32'h114, 32'h100, 32'h104,
             32'h108, 32'h10C, 32'h118, 32'h118, 32'h118};
    loadDefaults();
    put(32'h100, iT('h05, 0, 0, 16'h0005));
    put(32'h104, iT('h04, 1, 0, 16'h0002));
    put(32'h108, iT('h2b, 0, 31, 16'h0000));
    put(32'h10C, rT(31, 0, 0, 0, 'h08));
    put(32'h110, iT('h0d, 0, 1, 16'h0001));
    put(32'h114, jT('h03, 'h40));
    boot();
    runProg(11, 200);
    nTests++; if (nR != 11) begin nFail++; $display("FAIL ctl_timeout: got %0d retires want 11", nR); end
    for (int i = 0; i < 11 && i < fetchAddr.size(); i++) begin
      nTests++; if (fetchAddr[i] !== expA[i]) begin nFail++; $display("FAIL ctl_fetch[%0d]: got %h want %h", i, fetchAddr[i], expA[i]); end
    end
    nTests++; if (retCyc.size() < 3 || retCyc[0] != 3 || retCyc[1] != 6 || retCyc[2] != 10) begin
      nFail++; $display("FAIL ctl_retire_cycles: got %p want 3,6,10", retCyc); end
    nTests++; if (dmem[0] !== 32'h118) begin nFail++; $display("FAIL ctl_jal_link: got %h want 00000118", dmem[0]); end
  endtask

  task automatic test_boundaries();
    loadDefaults();
    dmem[3] = 32'hAAAA5555;
    put(32'h100, iT('h0d, 0, 1, 16'h0005));
    put(32'h104, rT(1, 1, 0, 0, 'h21));
    put(32'h108, iT('h2b, 0, 0, 16'h000C));
    put(32'h10C, 32'hFC000000);
    put(32'h110, iT('h2b, 0, 1, 16'h0010));
    boot();
    runProg(5, 100);
    nTests++; if (nR != 5) begin nFail++; $display("FAIL bnd_timeout: got %0d retires want 5", nR); end
    nTests++; if (dmem[3] !== 32'h0) begin nFail++; $display("FAIL bnd_r0_zero: got %h want 0", dmem[3]); end
    nTests++; if (illCnt != 1) begin nFail++; $display("FAIL bnd_illegal_pulses: got %0d want 1", illCnt); end
    nTests++; if (fetchAddr.size() < 5 || fetchAddr[4] !== 32'h110) begin nFail++; $display("FAIL bnd_illegal_pc: got %h want 00000110", fetchAddr.size() > 4 ? fetchAddr[4] : 32'hX); end
    nTests++; if (dmem[4] !== 32'h5) begin nFail++; $display("FAIL bnd_after_illegal: got %h want 5", dmem[4]); end
  endtask

  task automatic test_reset_in_mem();
    int rets = 0;
    loadDefaults(); dataWait = 50;
    dmem[5] = 32'h55;
    put(32'h100, iT('h0d, 0, 1, 16'h0007));
    put(32'h104, iT('h2b, 0, 1, 16'h0014));
    boot();
    runProg(1, 20);
    for (int i = 0; i < 20 && !dataReq; i++) @(negedge clk);
    nTests++; if ({dataReq, dataWe, dataAddr} !== {1'b1, 1'b1, 32'h14}) begin
      nFail++; $display("FAIL mem_req_before_rst: got %b/%b/%h want 1/1/00000014", dataReq, dataWe, dataAddr); end
    rst = 1'b0; #1;
    nTests++; if ({dataReq, dataWe, instReq} !== 3'b000) begin nFail++; $display("FAIL mem_rst_req: got %b want 000", {dataReq, dataWe, instReq}); end
    repeat (3) begin @(negedge clk); if (retire) rets++; end
    nTests++; if (rets != 0) begin nFail++; $display("FAIL mem_rst_retire: got %0d want 0", rets); end
    rst = 1'b1;
    @(negedge clk);
    nTests++; if ({instReq, instAddr} !== {1'b1, 32'h100}) begin nFail++; $display("FAIL mem_rst_refetch: got %b/%h want 1/00000100", instReq, instAddr); end
    nTests++; if (dmem[5] !== 32'h55) begin nFail++; $display("FAIL mem_store_abandoned: got %h want 00000055", dmem[5]); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_wait_states();
    test_control_flow();
    test_boundaries();
    test_reset_in_mem();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
